// File: rtl/vec_alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : vec_alu_pkg
//  Purpose  : Shared types and constants for the vector FP ALU
//  Revision : 1.0  initial release
// ============================================================================
package vec_alu_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_MUL = 2'b01,
    OP_SUB = 2'b10,
    OP_MOV = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ISSUE = 2'b01,
    S_WAIT  = 2'b10,
    S_DONE  = 2'b11
  } state_e;

  localparam logic [31:0] FP_QNAN = 32'h7FC00000;
  localparam logic [31:0] FP_SIGN = 32'h80000000;

endpackage
`default_nettype wire

// File: rtl/vector_fp_alu_lane.sv
`default_nettype none
// ============================================================================
//  Module   : fp_lane (+ adder_fp, multiplier_fp)
//  Purpose  : One FP lane: adder and multiplier units, op select, sticky done
//  Revision : 1.0  initial release
// ============================================================================

// Truncating single-precision adder; denormals flush to zero.
module adder_fp #(
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        ready,
  output logic        busy,
  output logic [32:0] result
);
  logic [31:0] opa, opb, x, y;
  logic [1:0]  cnt;
  logic [7:0]  d;
  logic [27:0] mx, my_raw, my, s, sn;
  logic [4:0]  p;
  logic [9:0]  en;
  logic [32:0] sum;
  logic        swap;
  logic        unused_bits;

  assign unused_bits = ^{sn[27:26], sn[2:0]};

  // Align the smaller magnitude to the larger, add/subtract, renormalise
  always_comb begin
    swap   = opb[30:0] > opa[30:0];
    x      = swap ? opb : opa;
    y      = swap ? opa : opb;
    d      = x[30:23] - y[30:23];
    mx     = (x[30:23] == 8'd0) ? 28'd0 : {2'b01, x[22:0], 3'b000};
    my_raw = (y[30:23] == 8'd0) ? 28'd0 : {2'b01, y[22:0], 3'b000};
    my     = (d > 8'd27) ? 28'd0 : (my_raw >> d);
    s      = (x[31] == y[31]) ? (mx + my) : (mx - my);
    p      = 5'd0;
    for (int i = 0; i < 28; i++) begin
      if (s[i]) p = 5'(i);
    end
    sn = (p == 5'd27) ? (s >> 1) : (s << (5'd26 - p));
    en = {2'b00, x[30:23]} + 10'(p) - 10'd26;
    if (s == 28'd0 || en[9] || en == 10'd0) sum = 33'd0;
    else if (en >= 10'd255)                 sum = {1'b1, x[31], 8'hFF, 23'd0};
    else                                    sum = {1'b0, x[31], en[7:0], sn[25:3]};
  end

  // Start latches operands; ready pulses LATENCY cycles later
  always_ff @(posedge clk) begin
    if (rst) begin
      opa <= '0; opb <= '0; cnt <= '0; busy <= 1'b0; ready <= 1'b0; result <= '0;
    end else begin
      ready <= 1'b0;
      if (start) begin
        opa <= a; opb <= b; cnt <= 2'(LATENCY - 1); busy <= 1'b1;
      end else if (busy) begin
        if (cnt == 2'd0) begin
          busy <= 1'b0; ready <= 1'b1; result <= sum;
        end else begin
          cnt <= cnt - 2'd1;
        end
      end
    end
  end
endmodule

// Truncating single-precision multiplier; denormals flush to zero.
module multiplier_fp #(
  parameter int LATENCY = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        ready,
  output logic        busy,
  output logic [32:0] result
);
  logic [31:0] opa, opb;
  logic [1:0]  cnt;
  logic [47:0] prod;
  logic [9:0]  e;
  logic [22:0] frac;
  logic        sgn;
  logic [32:0] mres;
  logic        unused_bits;

  assign unused_bits = ^prod[22:0];

  // Mantissa product with one-step normalisation
  always_comb begin
    sgn  = opa[31] ^ opb[31];
    prod = {1'b1, opa[22:0]} * {1'b1, opb[22:0]};
    e    = {2'b00, opa[30:23]} + {2'b00, opb[30:23]} + {9'd0, prod[47]} - 10'd127;
    frac = prod[47] ? prod[46:24] : prod[45:23];
    if (opa[30:23] == 8'd0 || opb[30:23] == 8'd0 || e[9] || e == 10'd0)
      mres = {1'b0, sgn, 31'd0};
    else if (e >= 10'd255)
      mres = {1'b1, sgn, 8'hFF, 23'd0};
    else
      mres = {1'b0, sgn, e[7:0], frac};
  end

  // Start latches operands; ready pulses LATENCY cycles later
  always_ff @(posedge clk) begin
    if (rst) begin
      opa <= '0; opb <= '0; cnt <= '0; busy <= 1'b0; ready <= 1'b0; result <= '0;
    end else begin
      ready <= 1'b0;
      if (start) begin
        opa <= a; opb <= b; cnt <= 2'(LATENCY - 1); busy <= 1'b1;
      end else if (busy) begin
        if (cnt == 2'd0) begin
          busy <= 1'b0; ready <= 1'b1; result <= mres;
        end else begin
          cnt <= cnt - 2'd1;
        end
      end
    end
  end
endmodule

module fp_lane
  import vec_alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  op_e         op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        ready,
  output logic        done,
  output logic [31:0] result
);
  logic        add_start, mul_start, add_ready, mul_ready, add_busy, mul_busy;
  logic        unit_ready;
  logic [31:0] b_eff;
  logic [32:0] add_res, mul_res;
  logic        lane_unused;

  // SUB is an add with B's sign flipped; -0.0 is not treated specially
  assign b_eff      = (op == OP_SUB) ? (b ^ FP_SIGN) : b;
  assign add_start  = start && (op == OP_ADD || op == OP_SUB);
  assign mul_start  = start && (op == OP_MUL);
  assign unit_ready = (op == OP_MUL) ? mul_ready : add_ready;
  assign ready      = unit_ready;
  assign result     = (op == OP_MUL) ? mul_res[31:0] : add_res[31:0];
  assign lane_unused = ^{add_res[32], mul_res[32], add_busy, mul_busy};

  adder_fp #(.LATENCY(2)) u_add (
    .clk(clk), .rst(rst), .start(add_start), .a(a), .b(b_eff),
    .ready(add_ready), .busy(add_busy), .result(add_res)
  );

  multiplier_fp #(.LATENCY(3)) u_mul (
    .clk(clk), .rst(rst), .start(mul_start), .a(a), .b(b),
    .ready(mul_ready), .busy(mul_busy), .result(mul_res)
  );

  // Sticky done: cleared by a new start, set by the unit's ready pulse
  always_ff @(posedge clk) begin
    if (rst)             done <= 1'b0;
    else if (start)      done <= 1'b0;
    else if (unit_ready) done <= 1'b1;
  end
endmodule
`default_nettype wire

// File: rtl/vector_fp_alu.sv
`default_nettype none
// ============================================================================
//  Module   : vector_fp_alu
//  Purpose  : Multi-lane FP vector ALU; streams VLEN elements through LANES
//             lanes in VLEN/LANES beats with per-beat timeout recovery
//  Revision : 1.0  initial release
// ============================================================================
module vector_fp_alu
  import vec_alu_pkg::*;
#(
  parameter int LANES   = 4,
  parameter int VLEN    = 16,
  parameter int W       = 32,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        op,
  input  logic [VLEN*W-1:0] vec_a,
  input  logic [VLEN*W-1:0] vec_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [VLEN*W-1:0] vec_out,
  output logic              busy,
  output logic              err_tmo
);
  localparam int BEATS = VLEN / LANES;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int TW    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  state_e            state;
  op_e               op_q;
  logic [BW-1:0]     beat;
  logic [TW-1:0]     tmo_cnt;
  logic [VLEN*W-1:0] a_q, b_q, res_buf;
  logic [LANES-1:0]  lane_ready, lane_done;
  logic [W-1:0]      lane_res [LANES];
  logic              lane_start, all_done, tmo_hit, last_beat;

  assign lane_start = (state == S_ISSUE) && (op_q != OP_MOV);
  // A lane whose ready pulses this cycle counts as done for beat completion
  assign all_done   = &(lane_done | lane_ready);
  assign tmo_hit    = (tmo_cnt == TW'(TIMEOUT - 1));
  assign last_beat  = (beat == BW'(BEATS - 1));

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign busy      = (state != S_IDLE);
  assign vec_out   = res_buf;

  generate
    for (genvar i = 0; i < LANES; i++) begin : g_lane
      logic [W-1:0] elem_a, elem_b;
      assign elem_a = a_q[(int'(beat) * LANES + i) * W +: W];
      assign elem_b = b_q[(int'(beat) * LANES + i) * W +: W];

      fp_lane u_lane (
        .clk(clk), .rst(rst), .start(lane_start), .op(op_q),
        .a(elem_a), .b(elem_b),
        .ready(lane_ready[i]), .done(lane_done[i]), .result(lane_res[i])
      );
    end
  endgenerate

  // Op sequencer: accept, issue each beat, gather lane results, hand off
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      op_q    <= OP_ADD;
      beat    <= '0;
      tmo_cnt <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_buf <= '0;
      err_tmo <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            op_q    <= op_e'(op);
            a_q     <= vec_a;
            b_q     <= vec_b;
            err_tmo <= 1'b0;
            beat    <= '0;
            state   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          tmo_cnt <= '0;
          if (op_q == OP_MOV) begin
            // MOV bypasses the units: copy A straight into the buffer
            for (int i = 0; i < LANES; i++) begin
              res_buf[(int'(beat) * LANES + i) * W +: W] <= a_q[(int'(beat) * LANES + i) * W +: W];
            end
            if (last_beat) state <= S_DONE;
            else           beat  <= beat + BW'(1);
          end else begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          tmo_cnt <= tmo_cnt + TW'(1);
          for (int i = 0; i < LANES; i++) begin
            // A real result arriving on the timeout cycle beats the NaN
            if (lane_ready[i] && !lane_done[i])
              res_buf[(int'(beat) * LANES + i) * W +: W] <= lane_res[i];
            else if (tmo_hit && !lane_done[i])
              res_buf[(int'(beat) * LANES + i) * W +: W] <= FP_QNAN;
          end
          if (all_done || tmo_hit) begin
            if (!all_done) err_tmo <= 1'b1;
            if (last_beat) begin
              state <= S_DONE;
            end else begin
              beat  <= beat + BW'(1);
              state <= S_ISSUE;
            end
          end
        end
        S_DONE: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
`default_nettype wire
